text_ci_arbiter: RTL and testbench

Shares the text controller's custom-instruction (CI) port between two requesters: requester 0 is the CPU CI path, requester 1 is a hardware status/debug text source. Requests are accepted and serialized onto the single CI master interface using round-robin arbitration with an optional per-requester lock, so that multi-character strings stay atomic. Each requester receives a response carrying ciResult. The block sits between the requesters and the text controller, in the same clock domain.

---
 rtl/text_ci_pkg.sv | 25 ++
 rtl/text_ci_rr_select.sv | 18 +
 rtl/text_ci_arbiter.sv | 134 +++++++++++++
 tb/tb_text_ci_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_ci_pkg.sv
// Shared types and constants for the text controller CI arbiter.
package text_ci_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} ciState_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] data;
    logic        lock;
  } ciReq_t;

  // Text controller CI sub-commands, carried in ciDataA[3:0]
  localparam logic [3:0] FG     = 4'h0;
  localparam logic [3:0] BG     = 4'h1;
  localparam logic [3:0] CHAR   = 4'h2;
  localparam logic [3:0] CLS    = 4'h3;
  localparam logic [3:0] SMALL  = 4'h4;
  localparam logic [3:0] CURSOR = 4'h5;
  localparam logic [3:0] CORR   = 4'h6;
  localparam logic [3:0] INFO   = 4'hF;

  localparam logic [31:0] TIMEOUT_RESP = 32'hDEADDEAD;

endpackage

// File: rtl/text_ci_rr_select.sv
// Combinational 2-way winner select: a held lock pins the grant, otherwise round-robin.
module text_ci_rr_select (
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  input  logic       lastGrant,
  input  logic [1:0] lockOwner,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (lockOwner[0] && lock[0])      win[0] = valid[0];
    else if (lockOwner[1] && lock[1]) win[1] = valid[1];
    else if (valid == 2'b11)          win = lastGrant ? 2'b01 : 2'b10;
    else                              win = valid;
  end

endmodule

// File: rtl/text_ci_arbiter.sv
// Serializes two requesters onto the text controller CI port (round-robin + lock).
// Optional watchdog in WAIT is compiled in with TEXT_ARB_TIMEOUT_EN.
module text_ci_arbiter
  import text_ci_pkg::*;
#(
  parameter logic [7:0] customInstructionNr = 8'd0,
  parameter int         timeoutCycles       = 1024
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        req0Valid,
  input  logic [3:0]  req0Op,
  input  logic [31:0] req0Data,
  input  logic        req0Lock,
  output logic        req0Ready,
  output logic        rsp0Valid,
  output logic [31:0] rsp0Data,
  input  logic        req1Valid,
  input  logic [3:0]  req1Op,
  input  logic [31:0] req1Data,
  input  logic        req1Lock,
  output logic        req1Ready,
  output logic        rsp1Valid,
  output logic [31:0] rsp1Data,
  output logic [7:0]  ciN,
  output logic [31:0] ciDataA,
  output logic [31:0] ciDataB,
  output logic        ciStart,
  output logic        ciCke,
  input  logic        ciDone,
  input  logic [31:0] ciResult,
  output logic        timeoutErr
);

  ciReq_t [1:0] req;
  ciState_e     state;
  logic [1:0]   valid, lock, win, accept, lockOwner;
  logic         grant, lastGrant, finish, expire;
  logic [31:0]  finData;

  assign req[0] = '{valid: req0Valid, op: req0Op, data: req0Data, lock: req0Lock};
  assign req[1] = '{valid: req1Valid, op: req1Op, data: req1Data, lock: req1Lock};
  assign valid  = {req[1].valid, req[0].valid};
  assign lock   = {req[1].lock, req[0].lock};

  text_ci_rr_select uSel (
    .valid     (valid),
    .lock      (lock),
    .lastGrant (lastGrant),
    .lockOwner (lockOwner),
    .win       (win)
  );

  assign accept    = (state == IDLE && resetN) ? win : 2'b00;
  assign req0Ready = accept[0];
  assign req1Ready = accept[1];
  assign ciN       = customInstructionNr;
  assign ciCke     = resetN;

`ifdef TEXT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(timeoutCycles) + 1;
  logic [CW-1:0] toCnt;

  // Fires on the edge where the WAIT counter reaches timeoutCycles-1
  assign expire = (state == WAIT) && !ciDone && (toCnt == CW'(timeoutCycles - 2));

  always_ff @(posedge clock) begin
    if (!resetN) begin
      toCnt      <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (|accept)            toCnt <= '0;
      else if (state == WAIT) toCnt <= toCnt + 1'b1;
      if (expire) timeoutErr <= 1'b1;
    end
  end
`else
  assign expire     = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  assign finish  = (state != IDLE) && (ciDone || expire);
  assign finData = ciDone ? ciResult : TIMEOUT_RESP;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= IDLE;
      ciStart   <= 1'b0;
      rsp0Valid <= 1'b0;
      rsp1Valid <= 1'b0;
      rsp0Data  <= '0;
      rsp1Data  <= '0;
      ciDataA   <= '0;
      ciDataB   <= '0;
      grant     <= 1'b0;
      lastGrant <= 1'b1;
      lockOwner <= 2'b00;
    end else begin
      ciStart   <= 1'b0;
      rsp0Valid <= 1'b0;
      rsp1Valid <= 1'b0;
      case (state)
        IDLE: begin
          // A lock the owner has dropped releases here, not at the next completion
          lockOwner <= lockOwner & lock;
          if (|win) begin
            grant   <= win[1];
            ciDataA <= {28'd0, req[win[1]].op};
            ciDataB <= req[win[1]].data;
            ciStart <= 1'b1;
            state   <= ISSUE;
          end
        end
        default: begin
          if (finish) begin
            if (grant) begin
              rsp1Valid <= 1'b1;
              rsp1Data  <= finData;
            end else begin
              rsp0Valid <= 1'b1;
              rsp0Data  <= finData;
            end
            lastGrant <= grant;
            lockOwner <= (ciDone && lock[grant]) ? (grant ? 2'b10 : 2'b01) : 2'b00;
            state     <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_ci_arbiter.sv
// Randomized/directed bench for text_ci_arbiter with a transaction-level reference model.
module tb_text_ci_arbiter;
  import text_ci_pkg::*;

  localparam int TO   = 16;
`ifdef TEXT_ARB_TIMEOUT_EN
  localparam int LONG = 10;
`else
  localparam int LONG = 40;
`endif

  logic        clock = 1'b0;
  logic        resetN;
  logic        req0Valid, req0Lock, req0Ready, rsp0Valid;
  logic [3:0]  req0Op;
  logic [31:0] req0Data, rsp0Data;
  logic        req1Valid, req1Lock, req1Ready, rsp1Valid;
  logic [3:0]  req1Op;
  logic [31:0] req1Data, rsp1Data;
  logic [7:0]  ciN;
  logic [31:0] ciDataA, ciDataB, ciResult;
  logic        ciStart, ciCke, ciDone, timeoutErr;

  text_ci_arbiter #(.customInstructionNr(8'd0), .timeoutCycles(TO)) dut (
    .clock(clock), .resetN(resetN),
    .req0Valid(req0Valid), .req0Op(req0Op), .req0Data(req0Data), .req0Lock(req0Lock),
    .req0Ready(req0Ready), .rsp0Valid(rsp0Valid), .rsp0Data(rsp0Data),
    .req1Valid(req1Valid), .req1Op(req1Op), .req1Data(req1Data), .req1Lock(req1Lock),
    .req1Ready(req1Ready), .rsp1Valid(rsp1Valid), .rsp1Data(rsp1Data),
    .ciN(ciN), .ciDataA(ciDataA), .ciDataB(ciDataB), .ciStart(ciStart), .ciCke(ciCke),
    .ciDone(ciDone), .ciResult(ciResult), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  // Staged stimulus, applied to the DUT at the next falling edge
  bit          sRst;
  bit          sV [2];
  bit          sL [2];
  logic [3:0]  sOp [2];
  logic [31:0] sD [2];

  // Text controller responder: -1 never completes, 0 completes in the start cycle
  int          doneDelay, pend;
  bit          spurious;
  logic [31:0] lastResult;

  // Reference model (transaction level)
  bit          mBusy, mStartNext, mErr;
  bit   [1:0]  mRspNext;
  logic [31:0] mRspData, mData;
  logic [3:0]  mOp;
  int          mGrant, mLast, mOwner, mCyc;

  int errors = 0, checks = 0;
  int obsGrant;
  int obsAcc [2];
  int rspCnt [2];

  task automatic modelReset();
    mBusy = 0; mStartNext = 0; mErr = 0; mRspNext = 2'b00; mRspData = '0;
    mLast = 1; mOwner = -1; mCyc = 0; pend = 0;
  endtask

  task automatic complete(input logic [31:0] d, input bit keepLock, input bit isTimeout);
    mRspNext[mGrant] = 1'b1;
    mRspData = d;
    mLast = mGrant;
    mOwner = keepLock ? mGrant : -1;
    if (isTimeout) mErr = 1;
    mBusy = 0;
  endtask

  task automatic step();
    logic [1:0]  eRdy, eRsp;
    logic [31:0] eDat;
    bit          eStart, eErr;
    int          win;
    @(negedge clock);
    resetN = sRst;
    req0Valid = sV[0]; req0Lock = sL[0]; req0Op = sOp[0]; req0Data = sD[0];
    req1Valid = sV[1]; req1Lock = sL[1]; req1Op = sOp[1]; req1Data = sD[1];
    ciDone = 1'b0;
    ciResult = $urandom;
    if (ciStart === 1'b1) begin
      if (doneDelay == 0) ciDone = 1'b1;
      else if (doneDelay > 0) pend = doneDelay;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) ciDone = 1'b1;
    end else if (spurious && !mBusy && $urandom_range(0, 3) == 0) begin
      ciDone = 1'b1;
    end
    if (ciDone) lastResult = ciResult;
    #1;
    obsGrant = req1Ready ? 1 : (req0Ready ? 0 : -1);
    if (req0Ready === 1'b1) obsAcc[0]++;
    if (req1Ready === 1'b1) obsAcc[1]++;
    if (!resetN) begin
      checks++;
      if ({req1Ready, req0Ready} !== 2'b00 || ciCke !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle ready=%b cke=%b want ready=00 cke=0", {req1Ready, req0Ready}, ciCke);
      end
      modelReset();
      return;
    end
    if (rsp0Valid === 1'b1) rspCnt[0]++;
    if (rsp1Valid === 1'b1) rspCnt[1]++;
    eStart = mStartNext; eRsp = mRspNext; eDat = mRspData; eErr = mErr;
    mStartNext = 0; mRspNext = 2'b00; eRdy = 2'b00;

    checks++;
    if (ciStart !== eStart || ciCke !== 1'b1) begin
      errors++;
      $display("FAIL sb_start ciStart=%b cke=%b want %b/1", ciStart, ciCke, eStart);
    end
    checks++;
    if ({rsp1Valid, rsp0Valid} !== eRsp) begin
      errors++;
      $display("FAIL sb_rsp_valid got=%b want=%b", {rsp1Valid, rsp0Valid}, eRsp);
    end
    if (eRsp[0] || eRsp[1]) begin
      checks++;
      if ((eRsp[0] ? rsp0Data : rsp1Data) !== eDat) begin
        errors++;
        $display("FAIL sb_rsp_data got=%h want=%h", eRsp[0] ? rsp0Data : rsp1Data, eDat);
      end
    end
    checks++;
    if (timeoutErr !== eErr) begin
      errors++;
      $display("FAIL sb_timeout_err got=%b want=%b", timeoutErr, eErr);
    end

    if (mBusy) begin
      checks++;
      if (ciDataA !== {28'd0, mOp} || ciDataB !== mData) begin
        errors++;
        $display("FAIL sb_operand A=%h B=%h want A=%h B=%h", ciDataA, ciDataB, {28'd0, mOp}, mData);
      end
      mCyc++;
      if (ciDone) complete(ciResult, sL[mGrant], 0);
`ifdef TEXT_ARB_TIMEOUT_EN
      else if (mCyc == TO - 1) complete(TIMEOUT_RESP, 0, 1);
`endif
    end else begin
      if (mOwner >= 0 && !sL[mOwner]) mOwner = -1;
      if (mOwner >= 0)            win = sV[mOwner] ? mOwner : -1;
      else if (sV[0] && sV[1])    win = 1 - mLast;
      else if (sV[0])             win = 0;
      else if (sV[1])             win = 1;
      else                        win = -1;
      if (win >= 0) begin
        eRdy[win] = 1'b1;
        mBusy = 1; mGrant = win; mOp = sOp[win]; mData = sD[win];
        mStartNext = 1; mCyc = -1;
      end
    end
    checks++;
    if ({req1Ready, req0Ready} !== eRdy) begin
      errors++;
      $display("FAIL sb_ready got=%b want=%b", {req1Ready, req0Ready}, eRdy);
    end
  endtask

  task automatic idleInputs();
    sV[0] = 0; sV[1] = 0; sL[0] = 0; sL[1] = 0;
  endtask

  task automatic waitGrant(input int k, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (obsGrant == k) ok = 1;
    end
  endtask

  task automatic test_reset();
    sRst = 0; idleInputs();
    repeat (3) step();
    checks++;
    if (ciStart !== 1'b0 || rsp0Valid !== 1'b0 || rsp1Valid !== 1'b0 || timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags start=%b rsp=%b%b terr=%b want all 0", ciStart, rsp1Valid, rsp0Valid, timeoutErr);
    end
    checks++;
    if (rsp0Data !== 32'd0 || rsp1Data !== 32'd0 || ciDataA !== 32'd0 || ciDataB !== 32'd0) begin
      errors++;
      $display("FAIL reset_data rsp0=%h rsp1=%h A=%h B=%h want 0", rsp0Data, rsp1Data, ciDataA, ciDataB);
    end
    sRst = 1;
    step();
    checks++;
    if (ciCke !== 1'b1 || ciN !== 8'd0) begin
      errors++;
      $display("FAIL reset_release cke=%b ciN=%h want 1/00", ciCke, ciN);
    end
  endtask

  task automatic test_single();
    logic [31:0] res;
    doneDelay = 0;
    sV[0] = 1; sOp[0] = FG; sD[0] = 32'h0000F800;
    step();
    checks++;
    if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready ready=%b%b want 01", req1Ready, req0Ready);
    end
    sV[0] = 0;
    step();
    res = lastResult;
    checks++;
    if (ciStart !== 1'b1 || ciDataA !== 32'd0 || ciDataB !== 32'h0000F800) begin
      errors++;
      $display("FAIL single_issue start=%b A=%h B=%h want 1/0/F800", ciStart, ciDataA, ciDataB);
    end
    step();
    checks++;
    if (rsp0Valid !== 1'b1 || rsp0Data !== res) begin
      errors++;
      $display("FAIL single_rsp valid=%b data=%h want 1/%h", rsp0Valid, rsp0Data, res);
    end
  endtask

  task automatic test_round_robin();
    int prev = -1, n = 0, bad = 0;
    obsAcc[0] = 0; obsAcc[1] = 0; rspCnt[0] = 0; rspCnt[1] = 0;
    sV[0] = 1; sV[1] = 1; sOp[0] = CHAR; sOp[1] = CHAR; sD[0] = 32'h41; sD[1] = 32'h42;
    repeat (16) begin
      step();
      if (obsGrant >= 0) begin
        if (obsGrant == prev) bad++;
        prev = obsGrant;
        n++;
      end
    end
    idleInputs();
    repeat (4) step();
    checks++;
    if (bad != 0 || n != 8) begin
      errors++;
      $display("FAIL rr_alternate repeats=%0d grants=%0d want 0/8", bad, n);
    end
    checks++;
    if (rspCnt[0] != obsAcc[0] || rspCnt[1] != obsAcc[1]) begin
      errors++;
      $display("FAIL rr_counts rsp=%0d/%0d acc=%0d/%0d", rspCnt[0], rspCnt[1], obsAcc[0], obsAcc[1]);
    end
  endtask

  task automatic test_lock();
    int phase = 0, n1 = 0, broke = 0, after = -1;
    sV[0] = 1; sV[1] = 1; sL[1] = 1; sOp[1] = CHAR;
    for (int i = 0; i < 60 && phase < 3; i++) begin
      sD[1] = 32'h30 + n1;
      step();
      if (obsGrant >= 0) begin
        if (phase == 0 && obsGrant == 1) begin phase = 1; n1 = 1; end
        else if (phase == 1) begin
          if (obsGrant == 1) n1++;
          else broke++;
        end else if (phase == 2) begin
          after = obsGrant; phase = 3;
        end
        if (phase == 1 && n1 == 5) begin phase = 2; sL[1] = 0; end
      end
    end
    idleInputs();
    repeat (3) step();
    checks++;
    if (broke != 0 || n1 != 5) begin
      errors++;
      $display("FAIL lock_atomic req1 run=%0d interleaved=%0d want 5/0", n1, broke);
    end
    checks++;
    if (after != 0) begin
      errors++;
      $display("FAIL lock_release first grant=%0d want 0", after);
    end
  endtask

  task automatic test_long_wait();
    bit ok;
    int starts = 0, unstable = 0, rspAt = -1;
    logic [31:0] d, res, rd;
    d = $urandom; res = '0; rd = '0;
    doneDelay = LONG;
    sV[1] = 1; sOp[1] = CLS; sD[1] = d;
    waitGrant(1, ok);
    sV[1] = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL long_accept no grant for requester 1"); end
    for (int i = 0; i < LONG + 4; i++) begin
      step();
      if (ciStart === 1'b1) starts++;
      if (i <= LONG && ciDataB !== d) unstable++;
      if (ciDone) res = lastResult;
      if (rsp1Valid === 1'b1) begin rspAt = i; rd = rsp1Data; end
    end
    doneDelay = 0;
    checks++;
    if (starts != 1 || unstable != 0) begin
      errors++;
      $display("FAIL long_strobe starts=%0d unstable=%0d want 1/0", starts, unstable);
    end
    checks++;
    if (rspAt != LONG + 1 || rd !== res) begin
      errors++;
      $display("FAIL long_rsp at=%0d data=%h want %0d/%h", rspAt, rd, LONG + 1, res);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    doneDelay = -1;
    sV[0] = 1; sOp[0] = INFO; sD[0] = $urandom;
    waitGrant(0, ok);
    sV[0] = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rstwait_accept no grant for requester 0"); end
    repeat (4) step();
    sRst = 0;
    step();
    sRst = 1; sV[0] = 1; sV[1] = 1; sOp[1] = BG; sD[1] = $urandom;
    step();
    checks++;
    if (ciStart !== 1'b0 || rsp0Valid !== 1'b0 || rsp1Valid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_quiet start=%b rsp=%b%b want 0/00", ciStart, rsp1Valid, rsp0Valid);
    end
    checks++;
    if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_first ready=%b%b want 01", req1Ready, req0Ready);
    end
    doneDelay = 0;
    idleInputs();
    repeat (3) step();
  endtask

`ifdef TEXT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int rspAt = -1, got1 = 0;
    logic [31:0] rd = '0;
    doneDelay = -1;
    sV[0] = 1; sOp[0] = CLS; sD[0] = $urandom;
    waitGrant(0, ok);
    sV[0] = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (rsp0Valid === 1'b1) begin rspAt = i; rd = rsp0Data; end
    end
    checks++;
    if (!ok || rspAt != TO || rd !== TIMEOUT_RESP || timeoutErr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rsp at=%0d data=%h err=%b want %0d/%h/1", rspAt, rd, timeoutErr, TO, TIMEOUT_RESP);
    end
    doneDelay = 0;
    sV[1] = 1; sD[1] = $urandom;
    waitGrant(1, ok);
    sV[1] = 0;
    repeat (3) begin
      step();
      if (rsp1Valid === 1'b1) got1++;
    end
    checks++;
    if (!ok || got1 != 1 || timeoutErr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover grant=%b rsp=%0d err=%b want 1/1/1", ok, got1, timeoutErr);
    end
  endtask
`endif

  task automatic test_random();
    int acc0, rsp0;
    acc0 = obsAcc[0] + obsAcc[1];
    rsp0 = rspCnt[0] + rspCnt[1];
    spurious = 1;
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        sV[k] = ($urandom_range(0, 3) != 0);
        sL[k] = ($urandom_range(0, 3) == 0);
        sOp[k] = 4'($urandom);
        sD[k] = $urandom;
      end
      doneDelay = $urandom_range(0, 4);
      step();
    end
    spurious = 0; doneDelay = 0;
    idleInputs();
    repeat (8) step();
    checks++;
    if (obsAcc[0] + obsAcc[1] - acc0 != rspCnt[0] + rspCnt[1] - rsp0) begin
      errors++;
      $display("FAIL random_conservation accepts=%0d responses=%0d",
               obsAcc[0] + obsAcc[1] - acc0, rspCnt[0] + rspCnt[1] - rsp0);
    end
  endtask

  initial begin
    resetN = 0; ciDone = 0; ciResult = '0;
    req0Valid = 0; req0Lock = 0; req0Op = '0; req0Data = '0;
    req1Valid = 0; req1Lock = 0; req1Op = '0; req1Data = '0;
    sOp[0] = '0; sOp[1] = '0; sD[0] = '0; sD[1] = '0;
    doneDelay = 0; spurious = 0; lastResult = '0;
    obsAcc[0] = 0; obsAcc[1] = 0; rspCnt[0] = 0; rspCnt[1] = 0;
    modelReset();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_long_wait();
    test_reset_in_wait();
`ifdef TEXT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
